// File: rtl/bp_mc_bridge_req_arbiter_pkg.sv
// Shared types for the BP-to-manycore request arbiter.
// Tag table entry layout and default credit depth.
package bp_mc_bridge_req_arbiter_pkg;

  localparam int max_out_credits_gp = 16;
  localparam int owner_width_gp     = 2;

  typedef struct packed {
    logic                      valid;
    logic [owner_width_gp-1:0] owner;
    logic                      load;
  } tag_entry_t;

endpackage

// File: rtl/bp_mc_bridge_req_arbiter_rr.sv
// Round-robin grant among num_req_p requesters.
// Ports: reqs_i, yumi_i (grant taken) -> v_o, tag_o, grants_o.
module bp_mc_bridge_req_arbiter_rr #(
  parameter int num_req_p = 2,
  localparam int lg_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] reqs_i,
  input  logic                 yumi_i,
  output logic                 v_o,
  output logic [lg_lp-1:0]     tag_o,
  output logic [num_req_p-1:0] grants_o
);

  logic [lg_lp-1:0] ptr_r;
  int               j;

  always_comb begin
    v_o      = 1'b0;
    tag_o    = '0;
    grants_o = '0;
    j        = 0;
    for (int i = 0; i < num_req_p; i++) begin
      j = (int'(ptr_r) + i) % num_req_p;
      if (!v_o && reqs_i[j]) begin
        v_o   = 1'b1;
        tag_o = lg_lp'(j);
      end
    end
    if (v_o) grants_o[tag_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ptr_r <= '0;
    end else if (yumi_i && v_o) begin
      ptr_r <= (tag_o == lg_lp'(num_req_p - 1))
             ? '0 : tag_o + 1'b1;
    end
  end

endmodule

// File: rtl/bp_mc_bridge_req_arbiter.sv
// Arbitrates requesters onto the manycore port with reg_id tags
// and credits; routes returns back to the owner by tag.
module bp_mc_bridge_req_arbiter
  import bp_mc_bridge_req_arbiter_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int reg_id_width_p    = 5,
  parameter int max_out_credits_p = max_out_credits_gp,
  parameter int data_width_p      = 32,
  parameter int pkt_width_p       = 64,
  localparam int cw_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]             req_load_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic                             out_v_o,
  output logic [pkt_width_p-1:0]           out_pkt_o,
  output logic [reg_id_width_p-1:0]        out_reg_id_o,
  input  logic                             out_ready_i,
  input  logic                             ret_v_i,
  input  logic [reg_id_width_p-1:0]        ret_reg_id_i,
  input  logic [data_width_p-1:0]          ret_data_i,
  output logic                             ret_yumi_o,
  output logic [num_req_p-1:0]             resp_v_o,
  output logic [data_width_p-1:0]          resp_data_o,
  input  logic [num_req_p-1:0]             resp_ready_i,
  input  logic                             drain_i,
  output logic [cw_lp-1:0]                 credits_used_o,
  output logic                             idle_o,
  output logic                             error_o
);

  localparam int lg_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int tw_lp = $clog2(max_out_credits_p);
  localparam logic [reg_id_width_p:0] max_tag_lp =
    (reg_id_width_p + 1)'(max_out_credits_p);

  tag_entry_t tbl_r [max_out_credits_p];
  logic [cw_lp-1:0] credits_r;
  logic             error_r;

  logic [max_out_credits_p-1:0] free;
  logic [tw_lp-1:0]             free_idx;
  logic                         any_free;
  logic [num_req_p-1:0]         eligible;
  logic [num_req_p-1:0]         grants;
  logic [lg_lp-1:0]             winner;
  logic                         issue;

  logic [tw_lp-1:0] ret_idx;
  tag_entry_t       ret_entry;
  logic             ret_hit;
  logic [lg_lp-1:0] ret_owner;
  logic             free_en;
  logic             err_set;

  // Free vector comes from registered state, so a tag released this
  // cycle only becomes allocatable on the next one.
  always_comb begin
    free     = '0;
    free_idx = '0;
    for (int i = 0; i < max_out_credits_p; i++) begin
      free[i] = ~tbl_r[i].valid;
    end
    for (int i = max_out_credits_p - 1; i >= 0; i--) begin
      if (free[i]) free_idx = tw_lp'(i);
    end
  end

  assign any_free = |free;
  assign eligible = req_v_i & {num_req_p{~drain_i & any_free}};

  bp_mc_bridge_req_arbiter_rr #(
    .num_req_p(num_req_p)
  ) rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reqs_i  (eligible),
    .yumi_i  (out_ready_i),
    .v_o     (out_v_o),
    .tag_o   (winner),
    .grants_o(grants)
  );

  assign issue        = out_v_o & out_ready_i;
  assign req_yumi_o   = issue ? grants : '0;
  assign out_pkt_o    = req_pkt_i[winner*pkt_width_p +: pkt_width_p];
  assign out_reg_id_o = reg_id_width_p'(free_idx);

  assign ret_idx   = ret_reg_id_i[tw_lp-1:0];
  assign ret_entry = tbl_r[ret_idx];
  assign ret_hit   = ({1'b0, ret_reg_id_i} < max_tag_lp)
                   & ret_entry.valid;
  assign ret_owner = ret_entry.owner[lg_lp-1:0];
  assign resp_data_o = ret_data_i;

  always_comb begin
    resp_v_o   = '0;
    ret_yumi_o = 1'b0;
    err_set    = 1'b0;
    if (ret_v_i) begin
      unique case (1'b1)
        ret_hit & ret_entry.load: begin
          resp_v_o[ret_owner] = 1'b1;
          ret_yumi_o = resp_ready_i[ret_owner];
        end
        ret_hit & ~ret_entry.load: ret_yumi_o = 1'b1;
        default: begin
          ret_yumi_o = 1'b1;
          err_set    = 1'b1;
        end
      endcase
    end
  end

  assign free_en = ret_yumi_o & ret_hit;

  // Issue targets a free entry and free targets a valid one, so the
  // two table writes never collide.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < max_out_credits_p; i++) begin
        tbl_r[i] <= '0;
      end
      credits_r <= '0;
      error_r   <= 1'b0;
    end else begin
      if (issue) begin
        tbl_r[free_idx].valid <= 1'b1;
        tbl_r[free_idx].owner <= owner_width_gp'(winner);
        tbl_r[free_idx].load  <= req_load_i[winner];
      end
      if (free_en) tbl_r[ret_idx].valid <= 1'b0;
      unique case ({issue, free_en})
        2'b10:   credits_r <= credits_r + 1'b1;
        2'b01:   credits_r <= credits_r - 1'b1;
        default: credits_r <= credits_r;
      endcase
      if (err_set) error_r <= 1'b1;
    end
  end

  assign credits_used_o = credits_r;
  assign idle_o         = (credits_r == '0);
  assign error_o        = error_r;

endmodule
